// File: rtl/lab3_disp_ctrl.sv
// Board display driver: latches a CPU value and shows it as hex on a 4-digit 7-seg display and on 16 LEDs.
// Latency: led follows update by 1 cycle; seg/dp/an follow a digit index change by 1 cycle.
// Backpressure: none; update is a single-cycle strobe and is always accepted.
//
// Ports:
//   fpga_clk, reset_n   clock and asynchronous active-low reset
//   data_in, pc_in      CPU result and program counter, captured on update
//   update              capture strobe (capture every cycle while held high)
//   halt                CPU halted; display blinks while high
//   sel_pc              0 = show data, 1 = show PC with upper digits zero
//   seg, dp, an         active-low segments {g,f,e,d,c,b,a}, decimal point, one-hot anodes
//   led                 captured data value, active high
module lab3_disp_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        fpga_clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic [7:0]  pc_in,
  input  logic        update,
  input  logic        halt,
  input  logic        sel_pc,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] led
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [15:0]   data_q;
  logic [7:0]    pc_q;
  logic          act_q;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  logic [15:0]   disp;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;
  logic          lz_blank;
  logic          dark;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  // Capture; the activity toggle gives a visible heartbeat on digit 0's dp.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      pc_q   <= '0;
      act_q  <= 1'b0;
      led    <= '0;
    end else if (update) begin
      data_q <= data_in;
      pc_q   <= pc_in;
      act_q  <= ~act_q;
      led    <= data_in;
    end
  end

  // Digit refresh: each digit stays lit for REFRESH_DIV cycles.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Blink timer runs only while halted and restarts from the visible phase.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!halt) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    disp = sel_pc ? {8'h00, pc_q} : data_q;
    nib  = disp[{idx, 2'b00} +: 4];
  end

  always_comb begin
    hex_seg = 7'h7F;
    case (nib)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd1:    lz_blank = (disp[15:4]  == 12'h000);
      2'd2:    lz_blank = (disp[15:8]  == 8'h00);
      2'd3:    lz_blank = (disp[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank && (BLANK_LZ != 0);
  end

  // Blink and blanking only darken an/seg; dp keeps tracking activity.
  always_comb begin
    dark  = halt & blink_ph;
    seg_d = (lz_blank || dark) ? 7'h7F : hex_seg;
    an_d  = (lz_blank || dark) ? 4'hF : ~(4'b0001 << idx);
    dp_d  = (idx == 2'd0) ? ~act_q : 1'b1;
  end

  // Registered pins: reset holds all digits dark so release cannot glitch an.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_lab3_disp_ctrl.sv
module tb_lab3_disp_ctrl;

  logic        fpga_clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [7:0]  pc_in;
  logic        update;
  logic        halt;
  logic        sel_pc;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] led;

  lab3_disp_ctrl #(.REFRESH_DIV(4), .BLINK_DIV(8), .BLANK_LZ(1)) dut (
    .fpga_clk(fpga_clk), .reset_n(reset_n), .data_in(data_in), .pc_in(pc_in),
    .update(update), .halt(halt), .sel_pc(sel_pc),
    .seg(seg), .dp(dp), .an(an), .led(led)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Cycle number, advanced on every rising edge.
  int cyc = 0;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] led;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Hand-decoded digit tables, index = digit position (0 = rightmost).
  localparam logic [3:0][3:0] AN_ALL    = {4'h7, 4'hB, 4'hD, 4'hE};
  localparam logic [3:0][3:0] AN_D1     = {4'hF, 4'hF, 4'hD, 4'hE};
  localparam logic [3:0][3:0] AN_D0     = {4'hF, 4'hF, 4'hF, 4'hE};
  localparam logic [3:0][6:0] SEG_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [3:0][6:0] SEG_1A2F  = {7'h79, 7'h08, 7'h24, 7'h0E};
  localparam logic [3:0][6:0] SEG_0030  = {7'h7F, 7'h7F, 7'h30, 7'h40};
  localparam logic [3:0][6:0] SEG_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [3:0][6:0] SEG_00C5  = {7'h7F, 7'h7F, 7'h46, 7'h12};
  localparam logic [3:0][6:0] SEG_0003  = {7'h7F, 7'h7F, 7'h7F, 7'h30};

  task automatic push_one(input int c, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic [15:0] l, input string nm);
    exp_t e;
    e.c = c; e.an = a; e.seg = s; e.dp = d; e.led = l; e.name = nm;
    q.push_back(e);
  endtask

  // After release at cycle r, digit k is shown during cycles r+1+4k .. r+4+4k (period 16).
  task automatic push_range(input int r, input int c0, input int c1,
                            input logic [3:0][3:0] ans, input logic [3:0][6:0] segs,
                            input logic dp0, input logic dark, input logic [15:0] l,
                            input string nm);
    for (int c = c0; c <= c1; c++) begin
      int d;
      d = ((c - r - 1) / 4) % 4;
      push_one(c, dark ? 4'hF : ans[d], dark ? 7'h7F : segs[d],
               (d == 0) ? dp0 : 1'b1, l, nm);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge fpga_clk);
      #1;
    end
  endtask

  // Asserts reset mid-count, holds it 5 cycles, releases; r = release cycle.
  task automatic do_reset(output int r);
    @(posedge fpga_clk);
    #1;
    reset_n = 1'b0;
    update  = 1'b0;
    halt    = 1'b0;
    sel_pc  = 1'b0;
    data_in = 16'h0000;
    pc_in   = 8'h00;
    push_one(cyc,     4'hF, 7'h7F, 1'b1, 16'h0000, "reset_async");
    push_one(cyc + 4, 4'hF, 7'h7F, 1'b1, 16'h0000, "reset_hold");
    repeat (5) @(posedge fpga_clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
  endtask

  // Monitor: pops every expectation due this cycle and compares pins.
  always @(negedge fpga_clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.c != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.c, cyc);
      end else if (an !== e.an || seg !== e.seg || dp !== e.dp || led !== e.led) begin
        n_bad++;
        $display("FAIL %s @cycle %0d: got an=%b seg=%h dp=%b led=%h, want an=%b seg=%h dp=%b led=%h",
                 e.name, cyc, an, seg, dp, led, e.an, e.seg, e.dp, e.led);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset_n = 1'b0;
    update  = 1'b0;
    halt    = 1'b0;
    sel_pc  = 1'b0;
    data_in = 16'h0000;
    pc_in   = 8'h00;
    repeat (3) @(posedge fpga_clk);
    #1;
    reset_n = 1'b1;
    // Put non-reset state everywhere so the next reset lands mid-count.
    data_in = 16'hBEEF;
    update  = 1'b1;
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    repeat (6) @(posedge fpga_clk);
    #1;

    // Reset: outputs clear asynchronously; first lit digit is "0" on an[0].
    do_reset(r);
    push_range(r, r + 1, r + 16, AN_D0, SEG_ZERO, 1'b1, 1'b0, 16'h0000, "zero_disp");
    wait_to(r + 17);

    // Capture and full hex rotation.
    do_reset(r);
    data_in = 16'h1A2F;
    update  = 1'b1;
    push_range(r, r + 1, r + 1,  AN_D0,  SEG_ZERO, 1'b1, 1'b0, 16'h1A2F, "cap_first");
    push_range(r, r + 2, r + 20, AN_ALL, SEG_1A2F, 1'b0, 1'b0, 16'h1A2F, "cap_1a2f");
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    wait_to(r + 21);

    // Leading-zero blanking.
    do_reset(r);
    data_in = 16'h0030;
    update  = 1'b1;
    push_range(r, r + 1, r + 1,  AN_D0, SEG_ZERO, 1'b1, 1'b0, 16'h0030, "lz_first");
    push_range(r, r + 2, r + 20, AN_D1, SEG_0030, 1'b0, 1'b0, 16'h0030, "lz_0030");
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    wait_to(r + 21);

    // PC view selected without a new capture.
    do_reset(r);
    data_in = 16'h1234;
    pc_in   = 8'hC5;
    update  = 1'b1;
    push_range(r, r + 1, r + 1,  AN_D0,  SEG_ZERO, 1'b1, 1'b0, 16'h1234, "pc_first");
    push_range(r, r + 2, r + 4,  AN_ALL, SEG_1234, 1'b0, 1'b0, 16'h1234, "data_view");
    push_range(r, r + 5, r + 20, AN_D1,  SEG_00C5, 1'b0, 1'b0, 16'h1234, "pc_view");
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    wait_to(r + 4);
    sel_pc = 1'b1;
    wait_to(r + 21);
    sel_pc = 1'b0;

    // Halt blink: 8 visible, 8 dark, repeat; halt dropped while dark.
    do_reset(r);
    data_in = 16'h1A2F;
    update  = 1'b1;
    push_range(r, r + 1,  r + 1,  AN_D0,  SEG_ZERO, 1'b1, 1'b0, 16'h1A2F, "blink_first");
    push_range(r, r + 2,  r + 12, AN_ALL, SEG_1A2F, 1'b0, 1'b0, 16'h1A2F, "blink_vis1");
    push_range(r, r + 13, r + 20, AN_ALL, SEG_1A2F, 1'b0, 1'b1, 16'h1A2F, "blink_dark1");
    push_range(r, r + 21, r + 28, AN_ALL, SEG_1A2F, 1'b0, 1'b0, 16'h1A2F, "blink_vis2");
    push_range(r, r + 29, r + 31, AN_ALL, SEG_1A2F, 1'b0, 1'b1, 16'h1A2F, "blink_dark2");
    push_range(r, r + 32, r + 40, AN_ALL, SEG_1A2F, 1'b0, 1'b0, 16'h1A2F, "halt_release");
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    wait_to(r + 4);
    halt = 1'b1;
    wait_to(r + 31);
    halt = 1'b0;
    wait_to(r + 41);

    // Back-to-back captures of 1, 2, 3.
    do_reset(r);
    data_in = 16'h0001;
    update  = 1'b1;
    push_one(r + 1, 4'hE, 7'h40, 1'b1, 16'h0001, "b2b_c1");
    push_one(r + 2, 4'hE, 7'h79, 1'b0, 16'h0002, "b2b_c2");
    push_one(r + 3, 4'hE, 7'h24, 1'b1, 16'h0003, "b2b_c3");
    push_one(r + 4, 4'hE, 7'h30, 1'b0, 16'h0003, "b2b_c4");
    push_range(r, r + 5, r + 20, AN_D0, SEG_0003, 1'b0, 1'b0, 16'h0003, "b2b_hold");
    @(posedge fpga_clk);
    #1;
    data_in = 16'h0002;
    @(posedge fpga_clk);
    #1;
    data_in = 16'h0003;
    @(posedge fpga_clk);
    #1;
    update = 1'b0;
    wait_to(r + 22);

    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending: %0d expectations never checked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
